// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement queue with CDB capture, operand query and mispredict rollback
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  input  logic             alloc_is_branch,
  input  logic             alloc_pred_taken,
  input  logic [31:0]      alloc_pc_alt,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             rob_full,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_value,
  input  logic             wb_taken,
  input  logic [TAG_W-1:0] q_tag1,
  input  logic [TAG_W-1:0] q_tag2,
  output logic             q_ready1,
  output logic             q_ready2,
  output logic [31:0]      q_value1,
  output logic [31:0]      q_value2,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_value,
  output logic [TAG_W-1:0] commit_tag,
  output logic             rollback,
  output logic [31:0]      rollback_pc
);
  logic [ROB_DEPTH-1:0] valid_q, valid_d, ready_q, ready_d, br_q, br_d;
  logic [ROB_DEPTH-1:0] pred_q, pred_d, taken_q, taken_d;
  logic [4:0]           rd_q [ROB_DEPTH];
  logic [4:0]           rd_d [ROB_DEPTH];
  logic [31:0]          pc_q [ROB_DEPTH];
  logic [31:0]          pc_d [ROB_DEPTH];
  logic [31:0]          value_q [ROB_DEPTH];
  logic [31:0]          value_d [ROB_DEPTH];
  logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d, wb_idx, q_idx1, q_idx2;
  logic [IDX_W:0]       count_q, count_d;
  logic                 commit_valid_q, commit_valid_d, rollback_q, rollback_d;
  logic [4:0]           commit_rd_q, commit_rd_d;
  logic [31:0]          commit_value_q, commit_value_d, rollback_pc_q, rollback_pc_d;
  logic [TAG_W-1:0]     commit_tag_q, commit_tag_d;
  logic                 retire, mispredict, do_alloc, do_wb;

  assign alloc_tag    = TAG_W'(tail_q) + TAG_W'(1);
  assign rob_full     = count_q == (IDX_W+1)'(ROB_DEPTH);
  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign commit_value = commit_value_q;
  assign commit_tag   = commit_tag_q;
  assign rollback     = rollback_q;
  assign rollback_pc  = rollback_pc_q;

  assign wb_idx     = IDX_W'(wb_tag - TAG_W'(1));
  assign retire     = rdy_in && valid_q[head_q] && ready_q[head_q];
  assign mispredict = retire && br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);
  // A full ROB can still accept when the head frees its slot on the same edge
  assign do_alloc   = rdy_in && alloc_valid && (!rob_full || retire) && !mispredict;
  assign do_wb      = rdy_in && wb_valid && wb_tag != '0 && valid_q[wb_idx] && !mispredict;

  assign q_idx1 = IDX_W'(q_tag1 - TAG_W'(1));
  assign q_idx2 = IDX_W'(q_tag2 - TAG_W'(1));
  assign {q_ready1, q_value1} = q_tag1 == '0 ? {1'b1, 32'd0} :
                                (wb_valid && wb_tag == q_tag1) ? {1'b1, wb_value} :
                                (valid_q[q_idx1] && ready_q[q_idx1]) ? {1'b1, value_q[q_idx1]} : 33'd0;
  assign {q_ready2, q_value2} = q_tag2 == '0 ? {1'b1, 32'd0} :
                                (wb_valid && wb_tag == q_tag2) ? {1'b1, wb_value} :
                                (valid_q[q_idx2] && ready_q[q_idx2]) ? {1'b1, value_q[q_idx2]} : 33'd0;

  always_comb begin
    valid_d        = valid_q;
    ready_d        = ready_q;
    br_d           = br_q;
    pred_d         = pred_q;
    taken_d        = taken_q;
    rd_d           = rd_q;
    pc_d           = pc_q;
    value_d        = value_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(retire);
    commit_valid_d = retire;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    commit_tag_d   = commit_tag_q;
    rollback_d     = mispredict;
    rollback_pc_d  = rollback_pc_q;
    if (do_wb) begin
      value_d[wb_idx] = wb_value;
      taken_d[wb_idx] = wb_taken;
      ready_d[wb_idx] = 1'b1;
    end
    if (retire) begin
      valid_d[head_q] = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + IDX_W'(1);
      commit_rd_d     = br_q[head_q] ? 5'd0 : rd_q[head_q];
      commit_value_d  = value_q[head_q];
      commit_tag_d    = TAG_W'(head_q) + TAG_W'(1);
    end
    // Allocation is applied last so it overrides a writeback to the same slot
    if (do_alloc) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = 1'b0;
      br_d[tail_q]    = alloc_is_branch;
      pred_d[tail_q]  = alloc_pred_taken;
      taken_d[tail_q] = 1'b0;
      rd_d[tail_q]    = alloc_rd;
      pc_d[tail_q]    = alloc_pc_alt;
      tail_d          = tail_q + IDX_W'(1);
    end
    if (mispredict) begin
      rollback_pc_d = pc_q[head_q];
      valid_d       = '0;
      ready_d       = '0;
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q        <= '0;
      ready_q        <= '0;
      br_q           <= '0;
      pred_q         <= '0;
      taken_q        <= '0;
      rd_q           <= '{default: '0};
      pc_q           <= '{default: '0};
      value_q        <= '{default: '0};
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      rollback_q     <= 1'b0;
      rollback_pc_q  <= '0;
    end else begin
      valid_q        <= valid_d;
      ready_q        <= ready_d;
      br_q           <= br_d;
      pred_q         <= pred_d;
      taken_q        <= taken_d;
      rd_q           <= rd_d;
      pc_q           <= pc_d;
      value_q        <= value_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_tag_q   <= commit_tag_d;
      rollback_q     <= rollback_d;
      rollback_pc_q  <= rollback_pc_d;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus random traffic against a program-order queue model
module tb_reorder_buffer;
  logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in;
  logic        alloc_valid, alloc_is_branch, alloc_pred_taken, wb_valid, wb_taken;
  logic [4:0]  alloc_rd, alloc_tag, wb_tag, q_tag1, q_tag2, commit_rd, commit_tag;
  logic [31:0] alloc_pc_alt, wb_value, q_value1, q_value2, commit_value, rollback_pc;
  logic        rob_full, q_ready1, q_ready2, commit_valid, rollback;
  int checks = 0, errors = 0;

  typedef struct {
    logic [4:0]  tag, rd;
    bit          br, pred, rdy, taken;
    logic [31:0] pc, val;
  } ent_t;
  ent_t        mq[$];
  logic [4:0]  next_tag, exp_rd, exp_tag;
  logic [31:0] exp_val, exp_pc;
  logic        exp_cv, exp_rb;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_is_branch(alloc_is_branch),
    .alloc_pred_taken(alloc_pred_taken), .alloc_pc_alt(alloc_pc_alt),
    .alloc_tag(alloc_tag), .rob_full(rob_full),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_taken(wb_taken),
    .q_tag1(q_tag1), .q_tag2(q_tag2), .q_ready1(q_ready1), .q_ready2(q_ready2),
    .q_value1(q_value1), .q_value2(q_value2),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_tag(commit_tag), .rollback(rollback), .rollback_pc(rollback_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_reset();
    mq.delete();
    next_tag = 5'd1;
    {exp_cv, exp_rb, exp_rd, exp_tag, exp_val, exp_pc} = '0;
  endtask

  // One clock edge of the architectural queue: retire oldest, capture result, append newest
  task automatic model_edge();
    ent_t h, e;
    bit ret, mis, full;
    exp_cv = 1'b0;
    exp_rb = 1'b0;
    if (!rdy_in) return;
    full = mq.size() == 16;
    ret  = mq.size() > 0 && mq[0].rdy;
    mis  = ret && mq[0].br && mq[0].taken != mq[0].pred;
    if (ret) begin
      h = mq[0];
      exp_cv = 1'b1;
      exp_rd = h.br ? 5'd0 : h.rd;
      exp_val = h.val;
      exp_tag = h.tag;
    end
    if (mis) begin
      exp_rb = 1'b1;
      exp_pc = h.pc;
      mq.delete();
      next_tag = 5'd1;
      return;
    end
    if (wb_valid && wb_tag != 0)
      foreach (mq[i]) if (mq[i].tag == wb_tag) begin
        mq[i].rdy = 1'b1;
        mq[i].val = wb_value;
        mq[i].taken = wb_taken;
      end
    if (ret) void'(mq.pop_front());
    if (alloc_valid && (!full || ret)) begin
      e.tag = next_tag; e.rd = alloc_rd; e.br = alloc_is_branch; e.pred = alloc_pred_taken;
      e.pc = alloc_pc_alt; e.rdy = 1'b0; e.taken = 1'b0; e.val = '0;
      mq.push_back(e);
      next_tag = next_tag == 5'd16 ? 5'd1 : next_tag + 5'd1;
    end
  endtask

  function automatic logic [32:0] model_query(input logic [4:0] t);
    if (t == 0) return {1'b1, 32'd0};
    if (wb_valid && wb_tag == t) return {1'b1, wb_value};
    foreach (mq[i]) if (mq[i].tag == t && mq[i].rdy) return {1'b1, mq[i].val};
    return 33'd0;
  endfunction

  task automatic idle();
    rdy_in = 1'b1; alloc_valid = 1'b0; alloc_rd = '0; alloc_is_branch = 1'b0;
    alloc_pred_taken = 1'b0; alloc_pc_alt = '0; wb_valid = 1'b0; wb_tag = '0;
    wb_value = '0; wb_taken = 1'b0; q_tag1 = '0; q_tag2 = '0;
  endtask

  task automatic alloc(input logic [4:0] rd, input bit br, input bit pred, input logic [31:0] pc);
    idle();
    alloc_valid = 1'b1; alloc_rd = rd; alloc_is_branch = br; alloc_pred_taken = pred; alloc_pc_alt = pc;
  endtask

  task automatic wb(input logic [4:0] t, input logic [31:0] v, input bit tk);
    idle();
    wb_valid = 1'b1; wb_tag = t; wb_value = v; wb_taken = tk;
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({commit_valid, rollback, rob_full, alloc_tag} !== {3'b000, 5'd1}) begin
      errors++;
      $display("FAIL reset_initial: got %h want %h", {commit_valid, rollback, rob_full, alloc_tag}, {3'b000, 5'd1});
    end
    alloc(5, 0, 0, 0); tick();
    alloc(6, 0, 0, 0); tick();
    alloc(7, 0, 0, 0); tick();
    wb(1, 32'h77, 0); tick();
    idle(); tick();
    #2 rst_in = 1'b1;
    #1;
    checks++;
    if ({commit_valid, commit_rd, commit_value, commit_tag, rollback, rollback_pc} !== '0) begin
      errors++;
      $display("FAIL reset_async_outputs: got %h want 0", {commit_valid, commit_rd, commit_value, commit_tag, rollback, rollback_pc});
    end
    checks++;
    if ({rob_full, alloc_tag} !== {1'b0, 5'd1}) begin
      errors++;
      $display("FAIL reset_async_ptrs: got %h want %h", {rob_full, alloc_tag}, {1'b0, 5'd1});
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_in_order();
    do_reset();
    alloc(5, 0, 0, 0); tick();
    alloc(6, 0, 0, 0); tick();
    alloc(7, 0, 0, 0); tick();
    wb(3, 32'h33, 0); tick();
    wb(1, 32'h11, 0); tick();
    idle(); tick();
    checks++;
    if ({commit_valid, commit_tag, commit_rd, commit_value} !== {1'b1, 5'd1, 5'd5, 32'h11}) begin
      errors++;
      $display("FAIL inorder_tag1: got %h want %h", {commit_valid, commit_tag, commit_rd, commit_value}, {1'b1, 5'd1, 5'd5, 32'h11});
    end
    tick();
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++;
      $display("FAIL inorder_tag3_waits: got %b want 0", commit_valid);
    end
    wb(2, 32'h22, 0); tick();
    idle(); tick();
    checks++;
    if ({commit_valid, commit_tag, commit_rd, commit_value} !== {1'b1, 5'd2, 5'd6, 32'h22}) begin
      errors++;
      $display("FAIL inorder_tag2: got %h want %h", {commit_valid, commit_tag, commit_rd, commit_value}, {1'b1, 5'd2, 5'd6, 32'h22});
    end
    tick();
    checks++;
    if ({commit_valid, commit_tag, commit_rd, commit_value} !== {1'b1, 5'd3, 5'd7, 32'h33}) begin
      errors++;
      $display("FAIL inorder_tag3: got %h want %h", {commit_valid, commit_tag, commit_rd, commit_value}, {1'b1, 5'd3, 5'd7, 32'h33});
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc(5'(i + 1), 0, 0, 0);
      tick();
    end
    idle(); #1;
    checks++;
    if ({rob_full, alloc_tag} !== {1'b1, 5'd1}) begin
      errors++;
      $display("FAIL full_after16: got %h want %h", {rob_full, alloc_tag}, {1'b1, 5'd1});
    end
    alloc(31, 0, 0, 0); tick();
    idle(); q_tag1 = 5'd16; #1;
    checks++;
    if ({rob_full, alloc_tag, q_ready1} !== {1'b1, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL full_drop17: got %h want %h", {rob_full, alloc_tag, q_ready1}, {1'b1, 5'd1, 1'b0});
    end
    wb(1, 32'hAA, 0); tick();
    alloc(20, 0, 0, 0); tick();
    checks++;
    if ({commit_valid, commit_tag, commit_rd, commit_value} !== {1'b1, 5'd1, 5'd1, 32'hAA}) begin
      errors++;
      $display("FAIL full_retire: got %h want %h", {commit_valid, commit_tag, commit_rd, commit_value}, {1'b1, 5'd1, 5'd1, 32'hAA});
    end
    idle(); q_tag1 = 5'd1; #1;
    checks++;
    if ({rob_full, alloc_tag, q_ready1} !== {1'b1, 5'd2, 1'b0}) begin
      errors++;
      $display("FAIL full_reuse_tag1: got %h want %h", {rob_full, alloc_tag, q_ready1}, {1'b1, 5'd2, 1'b0});
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc(9, 1, 1, 32'h100); tick();
    alloc(2, 0, 0, 0); tick();
    alloc(3, 0, 0, 0); tick();
    alloc(4, 0, 0, 0); tick();
    wb(2, 32'h22, 0); tick();
    wb(3, 32'h33, 0); tick();
    wb(4, 32'h44, 0); tick();
    wb(1, 32'h1, 0); tick();
    alloc(12, 0, 0, 0); tick();
    checks++;
    if ({commit_valid, commit_tag, commit_rd, rollback, rollback_pc} !== {1'b1, 5'd1, 5'd0, 1'b1, 32'h100}) begin
      errors++;
      $display("FAIL mispredict_pulse: got %h want %h", {commit_valid, commit_tag, commit_rd, rollback, rollback_pc}, {1'b1, 5'd1, 5'd0, 1'b1, 32'h100});
    end
    idle(); #1;
    checks++;
    if ({alloc_tag, rob_full} !== {5'd1, 1'b0}) begin
      errors++;
      $display("FAIL mispredict_flush: got %h want %h", {alloc_tag, rob_full}, {5'd1, 1'b0});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({commit_valid, rollback} !== 2'b00) begin
        errors++;
        $display("FAIL mispredict_no_commit cycle %0d: got %b want 00", i, {commit_valid, rollback});
      end
    end
    alloc(8, 1, 0, 32'h200); tick();
    wb(1, 32'h5, 0); tick();
    idle(); tick();
    checks++;
    if ({commit_valid, commit_tag, commit_rd, rollback} !== {1'b1, 5'd1, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL branch_correct: got %h want %h", {commit_valid, commit_tag, commit_rd, rollback}, {1'b1, 5'd1, 5'd0, 1'b0});
    end
  endtask

  task automatic test_bypass();
    do_reset();
    alloc(1, 0, 0, 0); tick();
    alloc(2, 0, 0, 0); tick();
    wb(2, 32'hABCD, 0); q_tag1 = 5'd2; q_tag2 = 5'd0; #1;
    checks++;
    if ({q_ready1, q_value1, q_ready2, q_value2} !== {1'b1, 32'hABCD, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h want %h", {q_ready1, q_value1, q_ready2, q_value2}, {1'b1, 32'hABCD, 1'b1, 32'd0});
    end
    q_tag2 = 5'd1; #1;
    checks++;
    if ({q_ready2, q_value2} !== 33'd0) begin
      errors++;
      $display("FAIL bypass_not_ready: got %h want 0", {q_ready2, q_value2});
    end
    tick();
    wb_valid = 1'b0; #1;
    checks++;
    if ({q_ready1, q_value1} !== {1'b1, 32'hABCD}) begin
      errors++;
      $display("FAIL query_array: got %h want %h", {q_ready1, q_value1}, {1'b1, 32'hABCD});
    end
  endtask

  task automatic test_stall();
    do_reset();
    alloc(3, 0, 0, 0); tick();
    wb(1, 32'h77, 0); tick();
    alloc(4, 0, 0, 0); rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (commit_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: got %b want 0", i, commit_valid);
      end
    end
    checks++;
    if (alloc_tag !== 5'd2) begin
      errors++;
      $display("FAIL stall_no_alloc: got %0d want 2", alloc_tag);
    end
    idle(); tick();
    checks++;
    if ({commit_valid, commit_tag, commit_rd, commit_value} !== {1'b1, 5'd1, 5'd3, 32'h77}) begin
      errors++;
      $display("FAIL stall_release: got %h want %h", {commit_valid, commit_tag, commit_rd, commit_value}, {1'b1, 5'd1, 5'd3, 32'h77});
    end
  endtask

  task automatic test_random();
    logic [32:0] e1, e2;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      idle();
      rdy_in = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 9) < 6) begin
        alloc_valid = 1'b1;
        alloc_rd = 5'($urandom_range(0, 31));
        alloc_is_branch = $urandom_range(0, 4) == 0;
        alloc_pred_taken = 1'($urandom);
        alloc_pc_alt = $urandom;
      end
      if ($urandom_range(0, 9) < 6) begin
        wb_valid = 1'b1;
        wb_tag = (mq.size() > 0 && $urandom_range(0, 3) != 0) ?
                 mq[$urandom_range(0, mq.size() - 1)].tag : 5'($urandom_range(0, 16));
        wb_value = $urandom;
        wb_taken = 1'($urandom);
      end
      q_tag1 = 5'($urandom_range(0, 16));
      q_tag2 = 5'($urandom_range(0, 16));
      #1;
      e1 = model_query(q_tag1);
      e2 = model_query(q_tag2);
      checks++;
      if ({alloc_tag, rob_full} !== {next_tag, mq.size() == 16}) begin
        errors++;
        $display("FAIL rand_alloc_state c%0d: got %h want %h", c, {alloc_tag, rob_full}, {next_tag, mq.size() == 16});
      end
      checks++;
      if ({q_ready1, q_value1, q_ready2, q_value2} !== {e1, e2}) begin
        errors++;
        $display("FAIL rand_query c%0d: got %h want %h", c, {q_ready1, q_value1, q_ready2, q_value2}, {e1, e2});
      end
      tick();
      checks++;
      if ({commit_valid, rollback, commit_rd, commit_value, commit_tag, rollback_pc} !==
          {exp_cv, exp_rb, exp_rd, exp_val, exp_tag, exp_pc}) begin
        errors++;
        $display("FAIL rand_commit c%0d: got %h want %h", c,
                 {commit_valid, rollback, commit_rd, commit_value, commit_tag, rollback_pc},
                 {exp_cv, exp_rb, exp_rd, exp_val, exp_tag, exp_pc});
      end
    end
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_in_order();
    test_full_wrap();
    test_mispredict();
    test_bypass();
    test_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
